fifo_reader: RTL and testbench
==============================

# fifo_reader

Read-side controller for the 32-bit, 8-entry register-file FIFO. It watches the FIFO's `empty` flag, issues `rd_en` pulses, and captures the FIFO's registered `d_out` on `rd_ack`. Captured words go into a small local skid buffer and are presented downstream on a valid/ready stream. It also counts delivered words and read-protocol errors, so a consumer never has to handle FIFO read timing directly.

## Interface
- `BUF_DEPTH`, default 4: skid-buffer entries. Must be a power of two and ≥ 3; 3 or more is required for one word per cycle.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: allows new FIFO reads while high.
- `flush` in 1: synchronous clear of the buffer and of any in-flight capture.
- `fifo_empty` in 1: FIFO `empty` flag.
- `fifo_rd_ack` in 1: FIFO `rd_ack`.
- `fifo_rd_err` in 1: FIFO `rd_err`.
- `fifo_d_out` in 32: FIFO `d_out`.
- `fifo_rd_en` out 1: read request to the FIFO.
- `m_data` out 32: head-of-buffer word.
- `m_valid` out 1: buffer non-empty.
- `m_ready` in 1: downstream accept.
- `busy` out 1: a read is pending, the buffer is non-empty, or the FSM is not IDLE.
- `rd_count` out 16: words delivered on the stream. Wraps modulo 2^16.
- `err_count` out 8: protocol errors. Saturates at 255.

## Operation
- **FSM states:**
  - IDLE: `enable` is 0 and nothing is held. Goes to RUN when `enable` is 1.
  - RUN: goes to STOP when `enable` is 0.
  - STOP: delivers leftovers. Goes to RUN when `enable` is 1. Goes to IDLE when `pending` is 0 and the buffer is empty.
- **Read issue:** `fifo_rd_en` = state==RUN & `enable` & !`flush` & !`fifo_empty` & (`buf_count` + `pending` < `BUF_DEPTH`).
  - It is combinational from registers and inputs only; there is no path from `m_ready`.
- **`pending` register:** loads `fifo_rd_en` every clock and marks a read whose response is due in the following cycle.
- **Capture (evaluated when `pending` is 1):**
  - `fifo_rd_ack` = 1: write `fifo_d_out` to the buffer tail.
  - `fifo_rd_ack` = 0, for example `fifo_rd_err` = 1: drop the response and increment `err_count`.
- **Unsolicited `fifo_rd_ack`:** `fifo_rd_ack` = 1 while `pending` = 0 is discarded and increments `err_count`.
- **Unsolicited `fifo_rd_err`:** `fifo_rd_err` = 1 while `pending` = 0 also increments `err_count`. At most one increment per cycle.
- **Buffer:** circular, with head/tail pointers of log2(`BUF_DEPTH`) bits that wrap naturally. `buf_count` is log2(`BUF_DEPTH`)+1 bits.
  - Push and pop in the same cycle leave `buf_count` unchanged.
  - A push into a full buffer is impossible by the credit rule. The bench asserts it never happens.
- **Stream:** `m_valid` = (`buf_count` ≠ 0). `m_data` = entry[head].
  - Pop happens on `m_valid` & `m_ready`, which increments `rd_count`.
  - `m_data` holds steady while `m_valid` is 1 and `m_ready` is 0.
- **Flush:**
  - Clears the buffer pointers, `buf_count` and `pending`, and blocks `rd_en` that cycle.
  - A response arriving in the flush cycle is discarded without error.
  - The FSM state and both counters are unaffected.
- **Priority within a cycle:** reset > flush > capture/pop.

## Timing
- **Reset values:** all outputs 0; state IDLE; `pending` 0; buffer empty. `m_data` reads 0 because the buffer entries are reset to 0.
- **Reset mid-operation:** any in-flight read is abandoned. A FIFO response arriving after reset release is unsolicited and counts as an error. Benches avoid this case.
- **Latency:** `rd_en` high in cycle N → FIFO `rd_ack`/`d_out` in cycle N+1 → captured at the end of N+1 → `m_valid`/`m_data` in cycle N+2.
- **Throughput:** one word per cycle with `m_ready` held at 1 and `BUF_DEPTH` ≥ 3.
- **Entering STOP:** `enable` falling removes `rd_en` in the same cycle. A read already pending is still captured.
- **Empty FIFO:** while `fifo_empty` is 1, `rd_en` is never asserted.
- **Backpressure:** with `m_ready` at 0, at most `BUF_DEPTH` words are held. `rd_en` stops when `buf_count` + `pending` = `BUF_DEPTH`.

## Test plan
- **Burst:** FIFO preloaded with 0x11, 0x22, 0x33; `enable` = 1; `m_ready` = 1.
  - `rd_en` high in cycles 0–2.
  - `m_valid` in cycles 2–4 with data in order.
  - `rd_count` = 3; `busy` returns to 0 one cycle after the last pop.
- **Backpressure:** FIFO holds 8 words; `m_ready` = 0.
  - Exactly 4 reads are issued and `m_data` = word0 is stable.
  - Raising `m_ready` drains all 8 in order.
  - Final FIFO `data_count` = 0; `err_count` = 0.
- **Enable drop mid-burst:** drop `enable` the cycle after the 2nd `rd_en`.
  - The pending word is still delivered; no further `rd_en`.
  - FSM passes RUN → STOP → IDLE once the buffer is empty.
- **Flush:** assert `flush` for one cycle while 2 words are buffered and 1 is pending.
  - `m_valid` = 0 in the next cycle; the pending response is dropped.
  - `err_count` is unchanged; `rd_count` is unchanged.
- **Error injection:**
  - Force `fifo_rd_ack` = 0 and `fifo_rd_err` = 1 for a pending read: `err_count` +1 and nothing is buffered.
  - Inject 300 unsolicited `rd_ack`: `err_count` saturates at 255.
- **Counter wrap:** stream 65,537 words. `rd_count` wraps to 1, and the data sequence is checked against a scoreboard.

Source files
------------

// File: rtl/fifo_reader_if.sv
// fifo_reader_if: bus bundle between the FIFO read controller, the FIFO it
// drains and the downstream stream consumer.
//   fifo_empty / fifo_rd_ack / fifo_rd_err / fifo_d_out : FIFO -> reader
//   fifo_rd_en                                          : reader -> FIFO
//   m_data / m_valid                                    : reader -> consumer
//   m_ready                                             : consumer -> reader
// modport master is the reader; modport slave is the FIFO/consumer side.
interface fifo_reader_if;
    logic        fifo_empty;
    logic        fifo_rd_ack;
    logic        fifo_rd_err;
    logic [31:0] fifo_d_out;
    logic        fifo_rd_en;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;

    modport master (
        input  fifo_empty, fifo_rd_ack, fifo_rd_err, fifo_d_out, m_ready,
        output fifo_rd_en, m_data, m_valid
    );

    modport slave (
        output fifo_empty, fifo_rd_ack, fifo_rd_err, fifo_d_out, m_ready,
        input  fifo_rd_en, m_data, m_valid
    );
endinterface

// File: rtl/fifo_reader.sv
// fifo_reader: read-side controller for the 32-bit register-file FIFO.
// Issues rd_en while credit allows, captures d_out on rd_ack one cycle later
// into a BUF_DEPTH skid buffer and presents it as a valid/ready stream.
// Ports:
//   clk, reset_n  : clock, async active-low reset
//   enable        : permits new FIFO reads
//   flush         : sync clear of buffer and in-flight capture
//   bus (master)  : FIFO read port + downstream stream (see fifo_reader_if)
//   busy          : read pending, buffer non-empty or FSM not IDLE
//   rd_count      : words delivered downstream, wraps mod 2^16
//   err_count     : read-protocol errors, saturates at 255
// BUF_DEPTH must be a power of two and >= 3 for one word per cycle.
module fifo_reader #(
    parameter int BUF_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          flush,
    fifo_reader_if.master bus,
    output logic          busy,
    output logic [15:0]   rd_count,
    output logic [7:0]    err_count
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_e;

    state_e        state_q, state_d;
    logic          pending_q, pending_d;
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   mem_q [BUF_DEPTH];
    logic [31:0]   mem_d [BUF_DEPTH];
    logic [15:0]   rd_count_q, rd_count_d;
    logic [7:0]    err_count_q, err_count_d;
    logic          rd_en, m_valid, push, pop, err_evt, credit_ok;

    // Words buffered plus the one in flight must leave a free slot, so a
    // capture can never land in a full buffer. No dependence on m_ready.
    assign credit_ok = ({1'b0, cnt_q} + {{CW{1'b0}}, pending_q}) < (CW+1)'(BUF_DEPTH);

    assign m_valid = (cnt_q != '0);
    assign push    = ~flush & pending_q & bus.fifo_rd_ack;
    assign pop     = ~flush & m_valid & bus.m_ready;
    // Expected response missing, or a response nobody asked for.
    assign err_evt = ~flush & (pending_q ? ~bus.fifo_rd_ack
                                         : (bus.fifo_rd_ack | bus.fifo_rd_err));

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = m_valid;
    assign bus.m_data     = mem_q[head_q];
    assign rd_count       = rd_count_q;
    assign err_count      = err_count_q;

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = STOP;
            STOP: begin
                if (enable)                           state_d = RUN;
                else if (!pending_q && cnt_q == '0)   state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        rd_en = (state_q == RUN) & enable & ~flush & ~bus.fifo_empty & credit_ok;
        busy  = pending_q | m_valid | (state_q != IDLE);
    end

    // Datapath next state. Flush wins over capture and pop; because flush
    // also masks rd_en, pending clears on the same edge.
    always_comb begin
        pending_d = rd_en;
        head_d    = head_q;
        tail_d    = tail_q;
        cnt_d     = cnt_q;
        mem_d     = mem_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) begin
                mem_d[tail_q] = bus.fifo_d_out;
                tail_d        = tail_q + 1'b1;
            end
            if (pop) head_d = head_q + 1'b1;
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
        rd_count_d  = rd_count_q + 16'(pop);
        err_count_d = (err_evt && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q   <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            rd_count_q  <= '0;
            err_count_q <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            pending_q   <= pending_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            rd_count_q  <= rd_count_d;
            err_count_q <= err_count_d;
            mem_q       <= mem_d;
        end
    end
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed bench for fifo_reader. Contains a behavioural
// 8-entry FIFO (registered rd_ack/d_out one cycle after rd_en) fed with the
// word sequence 0x11*(k+1), and a scoreboard of acked words checked at
// every stream handshake.
module tb_fifo_reader;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic        m_ready = 1'b0;
    logic        force_nack = 1'b0;
    logic        inject_ack = 1'b0;
    logic        busy;
    logic [15:0] rd_count;
    logic [7:0]  err_count;

    int checks = 0;
    int fails  = 0;

    logic [31:0] fmem [8];
    int          frp = 0, fwp = 0, fcnt = 0, fed = 0, feed_total = 0;
    int          rd_issued = 0, pops = 0;
    logic        f_ack = 1'b0, f_err = 1'b0;
    logic [31:0] f_dout = '0;
    logic [31:0] sb_q [$];

    fifo_reader_if bus();

    assign bus.fifo_empty  = (fcnt == 0);
    assign bus.fifo_rd_ack = f_ack;
    assign bus.fifo_rd_err = f_err;
    assign bus.fifo_d_out  = f_dout;
    assign bus.m_ready     = m_ready;

    fifo_reader #(.BUF_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .flush    (flush),
        .bus      (bus),
        .busy     (busy),
        .rd_count (rd_count),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input int k);
        return 32'(k + 1) * 32'h11;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO model; force_nack turns a read into rd_err without consuming.
    always @(posedge clk) begin : fifo_model
        logic do_rd, do_wr;
        do_rd = bus.fifo_rd_en && fcnt != 0 && !force_nack;
        do_wr = fed < feed_total && (fcnt - int'(do_rd)) < 8;
        f_ack <= do_rd || inject_ack;
        f_err <= bus.fifo_rd_en && (fcnt == 0 || force_nack);
        if (do_rd) begin
            f_dout <= fmem[frp];
            sb_q.push_back(fmem[frp]);
            frp <= (frp + 1) % 8;
        end
        if (do_wr) begin
            fmem[fwp] <= word_of(fed);
            fwp <= (fwp + 1) % 8;
            fed <= fed + 1;
        end
        fcnt <= fcnt - int'(do_rd) + int'(do_wr);
        if (bus.fifo_rd_en) rd_issued <= rd_issued + 1;
    end

    // Stream scoreboard and no-push-into-full monitor.
    always @(negedge clk) begin
        if (reset_n && bus.m_valid && bus.m_ready) begin
            chk("sb_avail", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) chk("sb_data", bus.m_data, sb_q.pop_front());
            pops <= pops + 1;
        end
        if (reset_n && dut.push)
            chk("push_full", 32'(int'(dut.cnt_q) >= DEPTH && !dut.pop), 0);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic load(input int n);
        feed_total = feed_total + n;
        repeat (n + 2) cyc();
    endtask

    task automatic wait_idle(input int lim);
        for (int i = 0; i < lim && busy; i++) begin
            cyc();
            smp();
        end
    endtask

    initial begin
        logic [31:0] exp_d [3];
        int p0, r0, e0, n;
        exp_d = '{32'h11, 32'h22, 32'h33};

        // reset state
        repeat (3) cyc();
        smp();
        chk("rst_rd_en", bus.fifo_rd_en, 0);
        chk("rst_valid", bus.m_valid, 0);
        chk("rst_data", bus.m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdc", rd_count, 0);
        chk("rst_err", err_count, 0);
        cyc();
        reset_n = 1'b1;

        // burst of three, m_ready high
        m_ready = 1'b1;
        load(3);
        enable = 1'b1;
        smp();
        for (int c = 0; c < 5; c++) begin
            cyc();
            if (c == 3) enable = 1'b0;
            smp();
            chk("burst_rd_en", bus.fifo_rd_en, c < 3);
            chk("burst_valid", bus.m_valid, c >= 2);
            if (c >= 2) chk("burst_data", bus.m_data, exp_d[c-2]);
        end
        wait_idle(4);
        chk("burst_busy", busy, 0);
        chk("burst_rdc", rd_count, 3);

        // backpressure: 8 words, m_ready low
        m_ready = 1'b0;
        load(8);
        r0 = rd_issued;
        p0 = pops;
        enable = 1'b1;
        repeat (10) cyc();
        smp();
        chk("bp_reads", rd_issued - r0, 4);
        chk("bp_rd_en", bus.fifo_rd_en, 0);
        chk("bp_valid", bus.m_valid, 1);
        chk("bp_head", bus.m_data, 32'h44);
        repeat (3) cyc();
        smp();
        chk("bp_hold", bus.m_data, 32'h44);
        chk("bp_rdc_hold", rd_count, 3);
        cyc();
        m_ready = 1'b1;
        n = 0;
        do begin
            cyc();
            smp();
            n++;
        end while ((fcnt != 0 || bus.m_valid || f_ack) && n < 40);
        chk("bp_drained", bus.m_valid, 0);
        chk("bp_fifo", fcnt, 0);
        chk("bp_pops", pops - p0, 8);
        chk("bp_err", err_count, 0);
        chk("bp_rdc", rd_count, 11);

        // enable drop after the second rd_en
        cyc();
        enable = 1'b0;
        smp();
        wait_idle(10);
        chk("drop_pre_idle", busy, 0);
        load(4);
        r0 = rd_issued;
        p0 = pops;
        enable = 1'b1;
        smp();
        cyc(); smp(); chk("drop_rd0", bus.fifo_rd_en, 1);
        cyc(); smp(); chk("drop_rd1", bus.fifo_rd_en, 1);
        cyc();
        enable = 1'b0;
        smp();
        chk("drop_rd2", bus.fifo_rd_en, 0);
        chk("drop_run", 32'(dut.state_q), 1);
        chk("drop_data0", bus.m_data, 32'hCC);
        cyc(); smp();
        chk("drop_stop", 32'(dut.state_q), 2);
        chk("drop_valid", bus.m_valid, 1);
        chk("drop_data1", bus.m_data, 32'hDD);
        wait_idle(10);
        chk("drop_idle", 32'(dut.state_q), 0);
        chk("drop_reads", rd_issued - r0, 2);
        chk("drop_pops", pops - p0, 2);
        chk("drop_fifo", fcnt, 2);

        // flush with 2 buffered and 1 pending
        m_ready = 1'b0;
        load(4);
        r0 = rd_count;
        e0 = err_count;
        enable = 1'b1;
        smp();
        cyc(); smp(); chk("fl_rd0", bus.fifo_rd_en, 1);
        cyc();
        cyc();
        cyc();
        flush = 1'b1;
        smp();
        chk("fl_block", bus.fifo_rd_en, 0);
        chk("fl_pre_valid", bus.m_valid, 1);
        chk("fl_pre_data", bus.m_data, 32'hEE);
        chk("fl_pre_cnt", dut.cnt_q, 2);
        chk("fl_pre_pend", dut.pending_q, 1);
        cyc();
        flush = 1'b0;
        enable = 1'b0;
        smp();
        chk("fl_valid", bus.m_valid, 0);
        chk("fl_err", err_count, e0);
        chk("fl_rdc", rd_count, r0);
        sb_q.delete();
        cyc(); smp();
        chk("fl_drop", bus.m_valid, 0);
        chk("fl_err2", err_count, e0);
        wait_idle(10);
        chk("fl_idle", busy, 0);
        chk("fl_fifo", fcnt, 3);

        // missing rd_ack on a pending read
        e0 = err_count;
        r0 = rd_count;
        cyc();
        force_nack = 1'b1;
        m_ready = 1'b1;
        enable = 1'b1;
        smp();
        cyc(); smp(); chk("nk_rd", bus.fifo_rd_en, 1);
        cyc();
        enable = 1'b0;
        smp();
        chk("nk_err_in", bus.fifo_rd_err, 1);
        chk("nk_valid", bus.m_valid, 0);
        cyc();
        force_nack = 1'b0;
        smp();
        chk("nk_err", err_count, 32'(e0 + 1));
        chk("nk_valid2", bus.m_valid, 0);
        chk("nk_fifo", fcnt, 3);
        wait_idle(10);
        cyc();
        enable = 1'b1;
        repeat (10) cyc();
        enable = 1'b0;
        smp();
        wait_idle(10);
        chk("nk_drain", rd_count, 32'(r0 + 3));
        chk("nk_fifo_end", fcnt, 0);

        // unsolicited rd_ack, then saturation
        e0 = err_count;
        r0 = rd_count;
        cyc();
        inject_ack = 1'b1;
        repeat (100) cyc();
        inject_ack = 1'b0;
        repeat (2) cyc();
        smp();
        chk("un_err", err_count, 32'(e0 + 100));
        chk("un_valid", bus.m_valid, 0);
        chk("un_rdc", rd_count, r0);
        cyc();
        inject_ack = 1'b1;
        repeat (200) cyc();
        inject_ack = 1'b0;
        repeat (2) cyc();
        smp();
        chk("un_sat", err_count, 255);

        // reset, then 65537 words for rd_count wrap
        cyc();
        reset_n = 1'b0;
        smp();
        chk("rst2_err", err_count, 0);
        chk("rst2_rdc", rd_count, 0);
        chk("rst2_busy", busy, 0);
        cyc();
        reset_n = 1'b1;
        chk("rst2_sb", 32'(sb_q.size()), 0);
        p0 = pops;
        feed_total = feed_total + 65537;
        enable = 1'b1;
        m_ready = 1'b1;
        n = 0;
        smp();
        while (pops - p0 < 65537 && n < 66000) begin
            cyc();
            smp();
            n++;
        end
        chk("wrap_pops", pops - p0, 65537);
        chk("wrap_tput", 32'(n <= 65537 + 16), 1);
        cyc();
        smp();
        chk("wrap_rdc", rd_count, 1);
        chk("wrap_valid", bus.m_valid, 0);
        chk("wrap_fifo", fcnt, 0);
        enable = 1'b0;
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
